// File: rtl/matmul_accel_pkg.sv
// -----------------------------------------------------------------------------
// matmul_accel_pkg
// Shared types and width helpers for the matmul_accel_engine slice.
//   state_t       : control FSM states (IDLE / RUN / DONE)
//   CYCLE_CNT_W   : width of the cycle_count performance counter
//   acc_width()   : accumulator width that can never overflow for a DIM-term
//                   dot product of IN_W x IN_W signed products
//   idx_width()   : width of the i/j/k loop indices (at least 1 bit)
//   flat_idx()    : row-major flat element index of (row, col)
// -----------------------------------------------------------------------------
package matmul_accel_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int CYCLE_CNT_W = 16;

   function automatic int acc_width(input int in_w, input int dim);
      return 2 * in_w + $clog2(dim) + 1;
   endfunction

   function automatic int idx_width(input int dim);
      return (dim > 1) ? $clog2(dim) : 1;
   endfunction

   function automatic int flat_idx(input int row, input int col, input int dim);
      return row * dim + col;
   endfunction

endpackage

// File: rtl/matmul_accel_post.sv
// -----------------------------------------------------------------------------
// matmul_accel_post
// Combinational post-processing for one result element:
//   total = sum + (ADD_BIAS ? bias : 0)   (exact, ACC_W+2 bits)
//   clip  = SATURATE ? clamp(total) : total mod 2^ACC_W
//   out   = (USE_RELU && clip < 0) ? 0 : clip
// Ports:
//   sum    in  ACC_W+2  exact dot-product sum, sign-extended
//   bias   in  ACC_W    bias element
//   result out ACC_W    post-processed element
// -----------------------------------------------------------------------------
module matmul_accel_post #(
   parameter int ACC_W    = 32,
   parameter int ADD_BIAS = 1,
   parameter int USE_RELU = 1,
   parameter int SATURATE = 1
) (
   input  logic signed [ACC_W+1:0] sum,
   input  logic signed [ACC_W-1:0] bias,
   output logic signed [ACC_W-1:0] result
);

   localparam int SUM_W = ACC_W + 2;

   localparam logic [ACC_W-1:0] MAX_VAL = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] MIN_VAL = {1'b1, {(ACC_W-1){1'b0}}};

   logic signed [ACC_W+1:0] total;
   logic                    overflow;
   logic signed [ACC_W-1:0] clipped;

   always_comb begin
      // NOTE: every signal assigned in this block gets a default first, so no
      // path can leave it unassigned and infer a latch.
      total    = sum;
      clipped  = total[ACC_W-1:0];
      result   = '0;

      if (ADD_BIAS != 0) begin
         total = sum + SUM_W'(bias);
      end

      // The value fits in ACC_W bits exactly when the top three bits agree.
      overflow = !((total[ACC_W+1] == total[ACC_W]) && (total[ACC_W] == total[ACC_W-1]));
      clipped  = total[ACC_W-1:0];
      if ((SATURATE != 0) && overflow) begin
         clipped = total[ACC_W+1] ? MIN_VAL : MAX_VAL;
      end

      result = clipped;
      if ((USE_RELU != 0) && clipped[ACC_W-1]) begin
         result = '0;
      end
   end

endmodule

// File: rtl/matmul_accel_engine.sv
// -----------------------------------------------------------------------------
// matmul_accel_engine
// Sequential signed matrix multiply C = post(A*B + bias), one MAC per clock.
// Optional feature macro: MATMUL_ACCEL_PERF_CNT_EN (cycle_count counter;
// when undefined cycle_count is tied to 0).
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   start        launch request, sampled only in IDLE
//   a_mat, b_mat DIM*DIM*IN_W  row-major operands
//   bias_mat     DIM*DIM*ACC_W row-major bias
//   busy         high while in RUN
//   done         one-cycle completion pulse (DONE state)
//   cycle_count  RUN cycles used by the last operation (saturating)
//   c_mat        DIM*DIM*ACC_W row-major result, held until rewritten
// -----------------------------------------------------------------------------
module matmul_accel_engine
   import matmul_accel_pkg::*;
#(
   parameter int IN_W     = 8,
   parameter int ACC_W    = 32,
   parameter int DIM      = 2,
   parameter int ADD_BIAS = 1,
   parameter int USE_RELU = 1,
   parameter int SATURATE = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [DIM*DIM*IN_W-1:0]    a_mat,
   input  logic [DIM*DIM*IN_W-1:0]    b_mat,
   input  logic [DIM*DIM*ACC_W-1:0]   bias_mat,
   output logic                       busy,
   output logic                       done,
   output logic [CYCLE_CNT_W-1:0]     cycle_count,
   output logic [DIM*DIM*ACC_W-1:0]   c_mat
);

   localparam int AW    = acc_width(IN_W, DIM);
   localparam int IDX_W = idx_width(DIM);
   localparam int NEL   = DIM * DIM;
   localparam int SUM_W = ACC_W + 2;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM - 1);

   state_t state_q, state_d;

   logic [IDX_W-1:0]        i_q, j_q, k_q;
   logic signed [AW-1:0]    acc_q, acc_next;
   logic [NEL*IN_W-1:0]     a_q, b_q;
   logic [NEL*ACC_W-1:0]    bias_q, c_q;

   logic signed [IN_W-1:0]   a_el, b_el;
   logic signed [2*IN_W-1:0] prod;
   logic signed [SUM_W-1:0]  sum_ext;
   logic signed [ACC_W-1:0]  bias_el, post_out;
   logic                     k_last, j_last, i_last, launch;
   int                       a_idx, b_idx, c_idx;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         // NOTE: registers use non-blocking assignment so every flop samples
         // the pre-edge values, independent of statement order.
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: if (start) state_d = S_RUN;
         S_RUN: begin
            busy = 1'b1;
            if (k_last && j_last && i_last) state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign launch = (state_q == S_IDLE) && start;
   assign k_last = (k_q == LAST);
   assign j_last = (j_q == LAST);
   assign i_last = (i_q == LAST);

   // ---------------- MAC datapath ----------------
   always_comb begin
      a_idx    = flat_idx(int'(i_q), int'(k_q), DIM);
      b_idx    = flat_idx(int'(k_q), int'(j_q), DIM);
      c_idx    = flat_idx(int'(i_q), int'(j_q), DIM);
      a_el     = a_q[a_idx*IN_W +: IN_W];
      b_el     = b_q[b_idx*IN_W +: IN_W];
      bias_el  = bias_q[c_idx*ACC_W +: ACC_W];
      prod     = a_el * b_el;
      acc_next = acc_q + AW'(prod);
      sum_ext  = SUM_W'(acc_next);
   end

   matmul_accel_post #(
      .ACC_W    (ACC_W),
      .ADD_BIAS (ADD_BIAS),
      .USE_RELU (USE_RELU),
      .SATURATE (SATURATE)
   ) u_post (
      .sum    (sum_ext),
      .bias   (bias_el),
      .result (post_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the result register is reset because c_mat must read 0 after
         // reset; the captured operands are reset too since they are cheap.
         i_q    <= '0;
         j_q    <= '0;
         k_q    <= '0;
         acc_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         bias_q <= '0;
         c_q    <= '0;
      end else if (launch) begin
         a_q    <= a_mat;
         b_q    <= b_mat;
         bias_q <= bias_mat;
         acc_q  <= '0;
         i_q    <= '0;
         j_q    <= '0;
         k_q    <= '0;
      end else if (state_q == S_RUN) begin
         if (k_last) begin
            c_q[c_idx*ACC_W +: ACC_W] <= post_out;
            acc_q <= '0;
            k_q   <= '0;
            if (j_last) begin
               j_q <= '0;
               i_q <= i_last ? '0 : i_q + 1'b1;
            end else begin
               j_q <= j_q + 1'b1;
            end
         end else begin
            acc_q <= acc_next;
            k_q   <= k_q + 1'b1;
         end
      end
   end

   assign c_mat = c_q;

   // ---------------- performance counter ----------------
`ifdef MATMUL_ACCEL_PERF_CNT_EN
   logic [CYCLE_CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (launch) begin
         cnt_q <= '0;
      end else if ((state_q == S_RUN) && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cycle_count = cnt_q;
`else
   assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_matmul_accel_engine.sv
// -----------------------------------------------------------------------------
// tb_matmul_accel_engine
// Directed bench for matmul_accel_engine with DIM=2, IN_W=8, ACC_W=32.
// Two instances share stimulus: dut (bias, saturation, ReLU on) and dut_wrap
// (bias on, SATURATE=0, USE_RELU=0) so wrap-around results can be checked.
// cycle_count is expected to read DIM^3 only when MATMUL_ACCEL_PERF_CNT_EN is
// defined for the build; otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module tb_matmul_accel_engine;
   import matmul_accel_pkg::*;

   localparam int IN_W  = 8;
   localparam int ACC_W = 32;
   localparam int DIM   = 2;
   localparam int NEL   = DIM * DIM;

`ifdef MATMUL_ACCEL_PERF_CNT_EN
   localparam logic [CYCLE_CNT_W-1:0] EXP_CC = 16'd8;
`else
   localparam logic [CYCLE_CNT_W-1:0] EXP_CC = 16'd0;
`endif

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     start = 1'b0;
   logic [NEL*IN_W-1:0]      a_mat = '0;
   logic [NEL*IN_W-1:0]      b_mat = '0;
   logic [NEL*ACC_W-1:0]     bias_mat = '0;
   logic                     busy, done, busy_w, done_w;
   logic [CYCLE_CNT_W-1:0]   cycle_count, cycle_count_w;
   logic [NEL*ACC_W-1:0]     c_mat, c_mat_w;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   matmul_accel_engine #(
      .IN_W(IN_W), .ACC_W(ACC_W), .DIM(DIM),
      .ADD_BIAS(1), .USE_RELU(1), .SATURATE(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a_mat(a_mat), .b_mat(b_mat), .bias_mat(bias_mat),
      .busy(busy), .done(done), .cycle_count(cycle_count), .c_mat(c_mat)
   );

   matmul_accel_engine #(
      .IN_W(IN_W), .ACC_W(ACC_W), .DIM(DIM),
      .ADD_BIAS(1), .USE_RELU(0), .SATURATE(0)
   ) dut_wrap (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a_mat(a_mat), .b_mat(b_mat), .bias_mat(bias_mat),
      .busy(busy_w), .done(done_w), .cycle_count(cycle_count_w), .c_mat(c_mat_w)
   );

   typedef struct {
      string               name;
      logic [NEL*IN_W-1:0]  a;
      logic [NEL*IN_W-1:0]  b;
      logic [NEL*ACC_W-1:0] bias;
      logic [NEL*ACC_W-1:0] exp_c;
      logic [NEL*ACC_W-1:0] exp_wrap;
   } vec_t;

   vec_t vecs[5];

   function automatic logic [NEL*IN_W-1:0] p8(input int e0, input int e1,
                                               input int e2, input int e3);
      return {e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
   endfunction

   function automatic logic [NEL*ACC_W-1:0] p32(input int e0, input int e1,
                                                 input int e2, input int e3);
      return {e3[31:0], e2[31:0], e1[31:0], e0[31:0]};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Waits (bounded) for done at negedges, counting busy cycles on the way.
   task automatic wait_done(input string name, output int busy_cycles);
      bit seen = 1'b0;
      busy_cycles = 0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else if (busy) busy_cycles++;
      end
      check({name, "_done_seen"}, 128'(seen), 128'(1));
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int bc;

      vecs[0] = '{"basic", p8(1, 2, 3, 4), p8(5, 6, 7, 8), p32(0, 0, 0, 0),
                  p32(19, 22, 43, 50), p32(19, 22, 43, 50)};
      vecs[1] = '{"relu", p8(1, -2, 3, -4), p8(2, 1, 1, 2), p32(0, 0, 0, 0),
                  p32(0, 0, 2, 0), p32(0, -3, 2, -5)};
      vecs[2] = '{"bias", p8(1, 0, 0, 1), p8(1, 2, 3, 4), p32(10, 20, 30, 40),
                  p32(11, 22, 33, 44), p32(11, 22, 33, 44)};
      vecs[3] = '{"sat_pos", p8(-128, -128, -128, -128), p8(-128, -128, -128, -128),
                  p32(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF),
                  p32(2147483647, 2147483647, 2147483647, 2147483647),
                  p32(-2147450881, -2147450881, -2147450881, -2147450881)};
      // -128*127*2 = -32512; plus -2^31 saturates to -2^31, which ReLU zeroes.
      vecs[4] = '{"sat_neg", p8(-128, -128, -128, -128), p8(127, 127, 127, 127),
                  p32(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000),
                  p32(0, 0, 0, 0),
                  p32(2147451136, 2147451136, 2147451136, 2147451136)};

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_cc", 128'(cycle_count), 128'(0));
      check("rst_c", 128'(c_mat), 128'(0));
      rst_n = 1'b1;

      // Table-driven operations.
      for (int v = 0; v < 5; v++) begin
         a_mat    = vecs[v].a;
         b_mat    = vecs[v].b;
         bias_mat = vecs[v].bias;
         @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         // Operands are captured at launch; scrambling them must not matter.
         a_mat    = ~vecs[v].a;
         b_mat    = ~vecs[v].b;
         bias_mat = '0;
         bc = busy ? 1 : 0;
         begin
            int more;
            wait_done(vecs[v].name, more);
            bc += more;
         end
         check({vecs[v].name, "_busy_cycles"}, 128'(bc), 128'(8));
         check({vecs[v].name, "_c"}, 128'(c_mat), 128'(vecs[v].exp_c));
         check({vecs[v].name, "_c_wrap"}, 128'(c_mat_w), 128'(vecs[v].exp_wrap));
         check({vecs[v].name, "_cc"}, 128'(cycle_count), 128'(EXP_CC));
         check({vecs[v].name, "_busy_at_done"}, 128'(busy), 128'(0));
         @(negedge clk);
         check({vecs[v].name, "_done_one_cycle"}, 128'(done), 128'(0));
         check({vecs[v].name, "_cc_hold"}, 128'(cycle_count), 128'(EXP_CC));
         check({vecs[v].name, "_c_hold"}, 128'(c_mat), 128'(vecs[v].exp_c));
      end

      // Start held high through RUN and DONE: no retrigger during RUN, relaunch
      // on the first IDLE cycle.
      a_mat    = vecs[0].a;
      b_mat    = vecs[0].b;
      bias_mat = vecs[0].bias;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      a_mat = vecs[2].a;
      b_mat = vecs[2].b;
      bias_mat = vecs[2].bias;
      bc = busy ? 1 : 0;
      begin
         int more;
         wait_done("held", more);
         bc += more;
      end
      check("held_busy_cycles", 128'(bc), 128'(8));
      check("held_c", 128'(c_mat), 128'(vecs[0].exp_c));
      @(negedge clk);
      check("held_idle_busy", 128'(busy), 128'(0));
      check("held_idle_done", 128'(done), 128'(0));
      @(negedge clk);
      check("held_relaunch", 128'(busy), 128'(1));
      start = 1'b0;
      wait_done("held2", bc);
      check("held2_c", 128'(c_mat), 128'(vecs[2].exp_c));
      check("held2_cc", 128'(cycle_count), 128'(EXP_CC));

      // Reset pulsed mid-RUN aborts without a done pulse.
      a_mat    = vecs[1].a;
      b_mat    = vecs[1].b;
      bias_mat = vecs[1].bias;
      pulse_start();
      repeat (3) @(negedge clk);
      check("abort_busy_before", 128'(busy), 128'(1));
      rst_n = 1'b0;
      #1;
      check("abort_busy", 128'(busy), 128'(0));
      check("abort_done", 128'(done), 128'(0));
      check("abort_c", 128'(c_mat), 128'(0));
      check("abort_cc", 128'(cycle_count), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int done_seen = 0;
         for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
         end
         check("abort_no_activity", 128'(done_seen), 128'(0));
      end

      // Next operation after the abort completes normally.
      a_mat    = vecs[0].a;
      b_mat    = vecs[0].b;
      bias_mat = vecs[0].bias;
      pulse_start();
      wait_done("post_abort", bc);
      check("post_abort_c", 128'(c_mat), 128'(vecs[0].exp_c));
      check("post_abort_cc", 128'(cycle_count), 128'(EXP_CC));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
